// File: rtl/riscv_pkg.sv
// Shared RV32 constants and the fetch-stage state encoding.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

    function automatic logic pc_aligned(input logic [XLEN-1:0] pc);
        return (pc[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_pc_unit.sv
// Instruction fetch PC sequencer: one outstanding imem request, redirect handling
// with kill of in-flight responses, and a held instruction slot toward decode.
module fetch_pc_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            misaligned
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] inst_data_q, inst_data_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            misaligned_q, misaligned_d;

    logic            redir_ok_s;
    logic            redir_bad_s;
    logic            req_fire_s;
    logic            inst_fire_s;
    logic [XLEN-1:0] pc_inc_s;

    assign redir_ok_s  = redirect_valid & pc_aligned(redirect_pc);
    assign redir_bad_s = redirect_valid & ~pc_aligned(redirect_pc);
    assign req_fire_s  = imem_req_valid & imem_req_ready;
    assign inst_fire_s = inst_valid & inst_ready;
    assign pc_inc_s    = pc_q + 32'd4;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            kill_q       <= 1'b0;
            inst_data_q  <= 32'h0000_0000;
            inst_pc_q    <= 32'h0000_0000;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_q       <= kill_d;
            inst_data_q  <= inst_data_d;
            inst_pc_q    <= inst_pc_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_d       = kill_q;
        inst_data_d  = inst_data_q;
        inst_pc_d    = inst_pc_q;
        misaligned_d = redir_bad_s;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (redir_ok_s) begin
                    pc_d = redirect_pc;
                end else begin
                    pc_d = pc_q;
                end
                // A redirect racing the handshake lets the old address out, so tag it dead.
                if (req_fire_s) begin
                    state_d = ST_WAIT;
                    kill_d  = redir_ok_s;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem_resp_valid) begin
                    kill_d = 1'b0;
                    if (!kill_q && !redir_ok_s) begin
                        inst_data_d = imem_resp_data;
                        inst_pc_d   = pc_q;
                        pc_d        = pc_inc_s;
                        state_d     = ST_HOLD;
                    end else begin
                        state_d = ST_REQ;
                    end
                end else if (redir_ok_s) begin
                    kill_d = 1'b1;
                end else begin
                    kill_d = kill_q;
                end
                if (redir_ok_s) begin
                    pc_d = redirect_pc;
                end else begin
                    pc_d = pc_d;
                end
            end
            ST_HOLD: begin
                if (redir_ok_s) begin
                    pc_d    = redirect_pc;
                    state_d = ST_REQ;
                end else if (inst_fire_s) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode.
    always_comb begin
        imem_req_valid = 1'b0;
        inst_valid     = 1'b0;
        unique case (state_q)
            ST_REQ:  imem_req_valid = 1'b1;
            ST_HOLD: inst_valid     = ~redirect_valid;
            default: begin
                imem_req_valid = 1'b0;
                inst_valid     = 1'b0;
            end
        endcase
        imem_req_addr = pc_q;
        inst_data     = inst_data_q;
        inst_pc       = inst_pc_q;
        misaligned    = misaligned_q;
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: a scoreboard of expected instructions checked by
// a monitor on every decode handshake, plus direct checks of request/reset behaviour.
module tb_fetch_pc_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        misaligned;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    int          lat       = 1;
    bit          word_mode = 1'b0;
    logic        hs;
    logic [31:0] ha;
    logic [31:0] paddr;
    int          cnt       = 0;

    fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return word_mode ? {a[31:2], 2'b11} : 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hold(input string name);
        int n = 0;
        while (!inst_valid && n < 40) begin
            tick();
            n++;
        end
        check({name, "_hold_timeout"}, {31'd0, inst_valid}, 32'd1);
    endtask

    task automatic accept_one(input logic [31:0] pc, input logic [31:0] data);
        exp_t e;
        int   n = 0;
        e.pc   = pc;
        e.data = data;
        sb_q.push_back(e);
        inst_ready = 1'b1;
        while (sb_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        inst_ready = 1'b0;
        check("accept_timeout", sb_q.size(), 32'd0);
        sb_q.delete();
    endtask

    // Memory model: one response lat cycles after each accepted request.
    initial begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0000_0000;
        paddr           = 32'h0000_0000;
        forever begin
            @(negedge clk);
            hs = imem_req_valid && imem_req_ready;
            ha = imem_req_addr;
            @(posedge clk);
            #1;
            imem_resp_valid = 1'b0;
            if (hs) begin
                paddr = ha;
                cnt   = lat;
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = mem_word(paddr);
                end
            end
        end
    end

    // Monitor: every decode handshake must match the oldest expected instruction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && inst_valid && inst_ready) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_inst: got pc %h data %h expected none", inst_pc, inst_data);
                end else begin
                    e = sb_q.pop_front();
                    check("inst_pc", inst_pc, e.pc);
                    check("inst_data", inst_data, e.data);
                end
            end
        end
    end

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        #1;
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst_data", inst_data, 32'h0000_0000);
        check("rst_inst_pc", inst_pc, 32'h0000_0000);
        check("rst_misaligned", {31'd0, misaligned}, 32'd0);
        check("rst_addr", imem_req_addr, 32'h0000_0000);
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_valid", {31'd0, imem_req_valid}, 32'd0);
        @(negedge clk);
        check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("first_req_addr", imem_req_addr, 32'h0000_0000);

        // Straight-line fetch stream.
        accept_one(32'h0000_0000, 32'h0000_0013);
        accept_one(32'h0000_0004, 32'h0000_0013);
        accept_one(32'h0000_0008, 32'h0000_0013);

        // Decode backpressure in HOLD.
        wait_hold("stall");
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", {31'd0, inst_valid}, 32'd1);
            check("stall_pc", inst_pc, 32'h0000_000C);
            check("stall_data", inst_data, 32'h0000_0013);
            check("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
        end
        tick();
        word_mode = 1'b1;
        accept_one(32'h0000_000C, 32'h0000_0013);

        // Redirect in HOLD, then redirect in WAIT killing a late response.
        wait_hold("hold16");
        lat            = 3;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        @(negedge clk);
        check("hold_redir_drop", {31'd0, inst_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_addr_200", imem_req_addr, 32'h0000_0200);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        @(negedge clk);
        check("kill_no_inst0", {31'd0, inst_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        lat            = 1;
        @(negedge clk);
        check("kill_no_inst1", {31'd0, inst_valid}, 32'd0);
        @(negedge clk);
        check("kill_no_inst2", {31'd0, inst_valid}, 32'd0);
        @(negedge clk);
        check("kill_no_inst3", {31'd0, inst_valid}, 32'd0);
        check("kill_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("kill_req_addr", imem_req_addr, 32'h0000_0100);
        accept_one(32'h0000_0100, 32'h0000_0103);

        // Misaligned redirect while a request is stalled.
        wait_hold("hold104");
        imem_req_ready = 1'b0;
        accept_one(32'h0000_0104, 32'h0000_0107);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        @(negedge clk);
        check("mis_before", {31'd0, misaligned}, 32'd0);
        check("stall_addr0", imem_req_addr, 32'h0000_0108);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("mis_pulse", {31'd0, misaligned}, 32'd1);
        check("stall_addr1", imem_req_addr, 32'h0000_0108);
        check("stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
        @(negedge clk);
        check("mis_after", {31'd0, misaligned}, 32'd0);
        check("stall_addr2", imem_req_addr, 32'h0000_0108);
        tick();
        imem_req_ready = 1'b1;
        accept_one(32'h0000_0108, 32'h0000_010B);

        // PC wrap at the top of the address space.
        wait_hold("hold10c");
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        accept_one(32'hFFFF_FFFC, 32'hFFFF_FFFF);
        imem_req_ready = 1'b0;
        @(negedge clk);
        check("wrap_addr", imem_req_addr, 32'h0000_0000);
        tick();

        // Redirect coinciding with the request handshake.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        imem_req_ready = 1'b1;
        @(negedge clk);
        check("race_old_addr", imem_req_addr, 32'h0000_0000);
        tick();
        redirect_valid = 1'b0;
        accept_one(32'h0000_0300, 32'h0000_0303);

        // Redirect in REQ without a handshake.
        imem_req_ready = 1'b0;
        @(negedge clk);
        check("req_addr_304", imem_req_addr, 32'h0000_0304);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0400;
        @(negedge clk);
        check("req_addr_hold", imem_req_addr, 32'h0000_0304);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("req_addr_400", imem_req_addr, 32'h0000_0400);
        tick();
        imem_req_ready = 1'b1;
        accept_one(32'h0000_0400, 32'h0000_0403);

        // Redirect in WAIT on the same cycle as the response.
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0500;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("wait_redir_addr", imem_req_addr, 32'h0000_0500);
        accept_one(32'h0000_0500, 32'h0000_0503);

        // Reset while waiting on memory; the stale response lands after release.
        lat = 3;
        tick();
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        #1;
        check("mid_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("mid_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("mid_rst_addr", imem_req_addr, 32'h0000_0000);
        check("mid_rst_inst_pc", inst_pc, 32'h0000_0000);
        check("mid_rst_inst_data", inst_data, 32'h0000_0000);
        tick();
        rst = 1'b0;
        lat = 1;
        @(negedge clk);
        check("post_rst_idle", {31'd0, imem_req_valid}, 32'd0);
        @(negedge clk);
        check("post_rst_req", {31'd0, imem_req_valid}, 32'd1);
        check("post_rst_addr", imem_req_addr, 32'h0000_0000);
        check("post_rst_no_inst", {31'd0, inst_valid}, 32'd0);
        tick();
        imem_req_ready = 1'b1;
        accept_one(32'h0000_0000, 32'h0000_0003);

        repeat (3) tick();
        check("sb_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
